// File: rtl/pipe_controller_if.sv
// Handshake bundle between the datapath and pipe_controller.
// Carries decode/hazard inputs and all pipeline control outputs.
interface pipe_controller_if #(
  parameter int ALUCW = 3
);
  logic [5:0]       opcode_d;
  logic [5:0]       funct_d;
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic [4:0]       rt_e;
  logic             zero_m;
  logic             reg_dst_e;
  logic             alu_src_e;
  logic [ALUCW-1:0] alu_control_e;
  logic             mem_write_m;
  logic             reg_write_w;
  logic             mem_to_reg_w;
  logic             pc_src;
  logic             jump_d;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;

  modport master (
    output opcode_d, funct_d, rs_d, rt_d, rt_e, zero_m,
    input  reg_dst_e, alu_src_e, alu_control_e, mem_write_m,
    input  reg_write_w, mem_to_reg_w, pc_src, jump_d,
    input  stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  opcode_d, funct_d, rs_d, rt_d, rt_e, zero_m,
    output reg_dst_e, alu_src_e, alu_control_e, mem_write_m,
    output reg_write_w, mem_to_reg_w, pc_src, jump_d,
    output stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined MIPS-style control unit: decode, D->E->M->W control regs,
// load-use stall and branch flush (hazards only with PIPE_CTRL_HAZARD_EN).
// Ports: clk, reset (async active-low), bus (pipe_controller_if.slave).
module pipe_controller #(
  parameter int ALUCW = 3
) (
  input logic              clk,
  input logic              reset,
  pipe_controller_if.slave bus
);

  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(0);
  localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(1);
  localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(2);
  localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(6);
  localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(7);

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             reg_dst;
    logic             alu_src;
    logic [ALUCW-1:0] alu_ctrl;
  } ex_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
  } mem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_t;

  ex_t  dec;
  ex_t  ctrl_e;
  mem_t ctrl_m;
  wb_t  ctrl_w;
  logic jump;
  logic pc_src;
  logic stall;
  logic flush_d;
  logic flush_e;
  logic flush_m;

  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j;

  assign is_r    = bus.opcode_d == 6'b000000;
  assign is_lw   = bus.opcode_d == 6'b100011;
  assign is_sw   = bus.opcode_d == 6'b101011;
  assign is_beq  = bus.opcode_d == 6'b000100;
  assign is_addi = bus.opcode_d == 6'b001000;
  assign is_j    = bus.opcode_d == 6'b000010;

  always_comb begin
    dec  = '0;
    jump = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (bus.funct_d)
          6'b100000: dec.alu_ctrl = ALU_ADD;
          6'b100010: dec.alu_ctrl = ALU_SUB;
          6'b100100: dec.alu_ctrl = ALU_AND;
          6'b100101: dec.alu_ctrl = ALU_OR;
          6'b101010: dec.alu_ctrl = ALU_SLT;
          default: begin
            // unknown funct: harmless add, no write
            dec.alu_ctrl  = ALU_ADD;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      is_lw: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      is_sw: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      is_beq: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      is_addi: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      is_j: jump = 1'b1;
      default: ;
    endcase
  end

  assign pc_src = ctrl_m.branch & bus.zero_m;

`ifdef PIPE_CTRL_HAZARD_EN
  logic load_use;

  assign load_use = ctrl_e.mem_to_reg
                  && (bus.rt_e != 5'd0)
                  && ((bus.rt_e == bus.rs_d)
                   || (bus.rt_e == bus.rt_d));

  // a taken branch kills the stalled instruction anyway
  assign stall   = load_use & ~pc_src;
  assign flush_d = pc_src;
  assign flush_e = load_use | pc_src;
  assign flush_m = pc_src;
`else
  logic unused_hz;

  assign unused_hz = ^{bus.rs_d, bus.rt_d, bus.rt_e};
  assign stall     = 1'b0;
  assign flush_d   = 1'b0;
  assign flush_e   = 1'b0;
  assign flush_m   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_e <= flush_e ? '0 : dec;
      if (flush_m) begin
        ctrl_m <= '0;
      end else begin
        ctrl_m.reg_write  <= ctrl_e.reg_write;
        ctrl_m.mem_to_reg <= ctrl_e.mem_to_reg;
        ctrl_m.mem_write  <= ctrl_e.mem_write;
        ctrl_m.branch     <= ctrl_e.branch;
      end
      ctrl_w.reg_write  <= ctrl_m.reg_write;
      ctrl_w.mem_to_reg <= ctrl_m.mem_to_reg;
    end
  end

  assign bus.reg_dst_e     = ctrl_e.reg_dst;
  assign bus.alu_src_e     = ctrl_e.alu_src;
  assign bus.alu_control_e = ctrl_e.alu_ctrl;
  assign bus.mem_write_m   = ctrl_m.mem_write;
  assign bus.reg_write_w   = ctrl_w.reg_write;
  assign bus.mem_to_reg_w  = ctrl_w.mem_to_reg;
  assign bus.pc_src        = pc_src;
  // decode path is combinational; mask it so reset reads all-zero
  assign bus.jump_d        = jump & reset;
  assign bus.stall_f       = stall;
  assign bus.stall_d       = stall;
  assign bus.flush_d       = flush_d;
  assign bus.flush_e       = flush_e;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller with an expectation scoreboard.
// Builds with or without PIPE_CTRL_HAZARD_EN.
module tb_pipe_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_BAD = 6'b000000;

`ifdef PIPE_CTRL_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  localparam int FE = 0;
  localparam int FD = 1;
  localparam int SD = 2;
  localparam int SF = 3;
  localparam int JD = 4;
  localparam int PC = 5;
  localparam int MR = 6;
  localparam int RW = 7;
  localparam int MW = 8;
  localparam int AS = 12;
  localparam int RD = 13;

  typedef struct {
    int          due;
    logic [13:0] mask;
    logic [13:0] val;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  pipe_controller_if #(.ALUCW(3)) bus ();

  pipe_controller #(.ALUCW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] pack_obs();
    return {bus.reg_dst_e, bus.alu_src_e, bus.alu_control_e,
            bus.mem_write_m, bus.reg_write_w, bus.mem_to_reg_w,
            bus.pc_src, bus.jump_d, bus.stall_f, bus.stall_d,
            bus.flush_d, bus.flush_e};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.opcode_d = op;
    bus.funct_d  = fn;
    bus.rs_d     = rs;
    bus.rt_d     = rt;
  endtask

  task automatic exb(input int dly, input int pos, input logic v,
                     input string tag);
    exp_t e;
    e.due       = cyc + dly;
    e.mask      = '0;
    e.val       = '0;
    e.mask[pos] = 1'b1;
    e.val[pos]  = v;
    e.tag       = tag;
    sb.push_back(e);
  endtask

  task automatic exac(input int dly, input logic [2:0] v,
                      input string tag);
    exp_t e;
    e.due       = cyc + dly;
    e.mask      = 14'h0E00;
    e.val       = '0;
    e.val[11:9] = v;
    e.tag       = tag;
    sb.push_back(e);
  endtask

  task automatic exall0(input string tag);
    exp_t e;
    e.due  = cyc;
    e.mask = '1;
    e.val  = '0;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic cycle();
    logic [13:0] obs;
    exp_t        e;
    @(negedge clk);
    obs = pack_obs();
    for (int i = 0; i < sb.size();) begin
      if (sb[i].due == cyc) begin
        e = sb[i];
        sb.delete(i);
        checks++;
        assert ((obs & e.mask) === (e.val & e.mask))
        else begin
          failures++;
          $error("FAIL %s cyc=%0d observed=%h expected=%h",
                 e.tag, cyc, obs & e.mask, e.val & e.mask);
        end
      end else begin
        i++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.rt_e   = 5'd0;
    bus.zero_m = 1'b0;
    drive(OP_LW, F_ADD, 5'd0, 5'd0);

    // reset held with lw on the decode inputs
    for (int i = 0; i < 3; i++) begin
      exall0("rst_hold");
      cycle();
    end

    // cycle 3: release, lw decoded
    reset = 1'b1;
    exb(1, AS, 1'b1, "lw_alu_src");
    exac(1, 3'b010, "lw_aluc");
    exb(2, MW, 1'b0, "lw_mw");
    exb(3, RW, 1'b1, "lw_rw");
    exb(3, MR, 1'b1, "lw_mr");
    cycle();

    // 4: add, lw in E with rt_e=0
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    exb(0, SF, 1'b0, "lw_noconf_sf");
    exac(1, 3'b010, "add_aluc");
    exb(1, RD, 1'b1, "add_rd");
    exb(3, RW, 1'b1, "add_rw");
    exb(3, MR, 1'b0, "add_mr");
    cycle();

    // 5: sub back-to-back
    drive(OP_R, F_SUB, 5'd1, 5'd2);
    exac(1, 3'b110, "sub_aluc");
    exb(3, RW, 1'b1, "sub_rw");
    cycle();

    drive(OP_R, F_AND, 5'd1, 5'd2);
    exac(1, 3'b000, "and_aluc");
    cycle();
    drive(OP_R, F_OR, 5'd1, 5'd2);
    exac(1, 3'b001, "or_aluc");
    cycle();
    drive(OP_R, F_SLT, 5'd1, 5'd2);
    exac(1, 3'b111, "slt_aluc");
    cycle();

    // 9: unknown funct
    drive(OP_R, F_BAD, 5'd1, 5'd2);
    exac(1, 3'b010, "badfn_aluc");
    exb(1, RD, 1'b1, "badfn_rd");
    exb(3, RW, 1'b0, "badfn_rw");
    cycle();

    // 10: jump
    drive(OP_J, F_ADD, 5'd0, 5'd0);
    exb(0, JD, 1'b1, "j_jump");
    exb(1, RD, 1'b0, "j_rd");
    exac(1, 3'b000, "j_aluc");
    exb(3, RW, 1'b0, "j_rw");
    cycle();

    // 11: unlisted opcode
    drive(OP_BAD, F_ADD, 5'd0, 5'd0);
    exb(0, JD, 1'b0, "bad_jump");
    exb(1, AS, 1'b0, "bad_as");
    exac(1, 3'b000, "bad_aluc");
    exb(3, RW, 1'b0, "bad_rw");
    cycle();

    // 12: sw, 13: addi
    drive(OP_SW, F_ADD, 5'd0, 5'd0);
    exb(1, AS, 1'b1, "sw_as");
    exb(2, MW, 1'b1, "sw_mw");
    exb(3, RW, 1'b0, "sw_rw");
    cycle();
    drive(OP_ADDI, F_ADD, 5'd0, 5'd0);
    exb(1, AS, 1'b1, "addi_as");
    exac(1, 3'b010, "addi_aluc");
    exb(2, MW, 1'b0, "addi_mw");
    exb(3, RW, 1'b1, "addi_rw");
    cycle();

    // 14: lw rt=5; 15: consumer rs=5
    drive(OP_LW, F_ADD, 5'd0, 5'd5);
    exb(3, RW, 1'b1, "lu_lw_rw");
    cycle();
    drive(OP_R, F_ADD, 5'd5, 5'd9);
    bus.rt_e = 5'd5;
    exb(0, SF, HZ, "lu_stall_f");
    exb(0, SD, HZ, "lu_stall_d");
    exb(0, FE, HZ, "lu_flush_e");
    exb(0, FD, 1'b0, "lu_flush_d");
    exb(1, RD, ~HZ, "lu_bubble_rd");
    exac(1, HZ ? 3'b000 : 3'b010, "lu_bubble_aluc");
    exb(3, RW, ~HZ, "lu_bubble_rw");
    cycle();
    // 16: consumer re-presented, stall must drop
    bus.rt_e = 5'd9;
    exb(0, SF, 1'b0, "lu_one_cycle_sf");
    exb(0, FE, 1'b0, "lu_one_cycle_fe");
    exb(1, RD, 1'b1, "lu_retry_rd");
    cycle();

    // 17: lw rt=0; 18: rs=0 must not stall
    bus.rt_e = 5'd0;
    drive(OP_LW, F_ADD, 5'd0, 5'd0);
    cycle();
    drive(OP_R, F_ADD, 5'd0, 5'd0);
    exb(0, SF, 1'b0, "lu_rt0_sf");
    exb(0, SD, 1'b0, "lu_rt0_sd");
    exb(0, FE, 1'b0, "lu_rt0_fe");
    cycle();

    // 19: lw; 20: match on rt_d
    drive(OP_LW, F_ADD, 5'd0, 5'd4);
    cycle();
    drive(OP_R, F_ADD, 5'd3, 5'd4);
    bus.rt_e = 5'd4;
    exb(0, SF, HZ, "lu_rtd_sf");
    exb(0, FE, HZ, "lu_rtd_fe");
    cycle();
    bus.rt_e = 5'd0;
    cycle();

    // 22: beq, 23: sw, 24: addi with beq taken in M
    drive(OP_BEQ, F_ADD, 5'd1, 5'd2);
    exac(1, 3'b110, "beq_aluc");
    cycle();
    drive(OP_SW, F_ADD, 5'd1, 5'd2);
    cycle();
    drive(OP_ADDI, F_ADD, 5'd1, 5'd2);
    bus.zero_m = 1'b1;
    exb(0, PC, 1'b1, "br_pc_src");
    exb(0, FD, HZ, "br_flush_d");
    exb(0, FE, HZ, "br_flush_e");
    exb(0, SF, 1'b0, "br_stall_f");
    exb(1, MW, ~HZ, "br_flush_m_mw");
    exac(1, HZ ? 3'b000 : 3'b010, "br_flush_e_aluc");
    cycle();
    // 25: zero_m high but no branch in M
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    exb(0, PC, 1'b0, "zero_nobranch_pc");
    cycle();
    bus.zero_m = 1'b0;

    // 26: beq not taken
    drive(OP_BEQ, F_ADD, 5'd1, 5'd2);
    cycle();
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    cycle();
    exb(0, PC, 1'b0, "beq_not_taken_pc");
    exb(0, FD, 1'b0, "beq_not_taken_fd");
    cycle();

    // 29: beq, 30: lw, 31: load-use while beq taken
    drive(OP_BEQ, F_ADD, 5'd1, 5'd2);
    cycle();
    drive(OP_LW, F_ADD, 5'd0, 5'd7);
    exb(3, RW, ~HZ, "br_lu_lw_rw");
    cycle();
    drive(OP_R, F_ADD, 5'd7, 5'd1);
    bus.rt_e   = 5'd7;
    bus.zero_m = 1'b1;
    exb(0, PC, 1'b1, "brlu_pc_src");
    exb(0, SF, 1'b0, "brlu_stall_f");
    exb(0, SD, 1'b0, "brlu_stall_d");
    exb(0, FE, HZ, "brlu_flush_e");
    exb(0, FD, HZ, "brlu_flush_d");
    cycle();
    bus.rt_e   = 5'd0;
    bus.zero_m = 1'b0;
    drive(OP_BAD, F_ADD, 5'd0, 5'd0);
    cycle();

    // 33: lw, 34: add, 35: async reset mid-flight
    drive(OP_LW, F_ADD, 5'd0, 5'd0);
    cycle();
    drive(OP_R, F_ADD, 5'd1, 5'd2);
    cycle();
    reset = 1'b0;
    exall0("rst_mid");
    exb(1, RW, 1'b0, "rst_discard_rw");
    cycle();
    // 36: release with addi
    reset = 1'b1;
    drive(OP_ADDI, F_ADD, 5'd0, 5'd0);
    exb(1, AS, 1'b1, "post_rst_as");
    exb(1, RW, 1'b0, "post_rst_w1");
    exb(2, RW, 1'b0, "post_rst_w2");
    exb(3, RW, 1'b1, "post_rst_w3");
    cycle();
    drive(OP_BAD, F_ADD, 5'd0, 5'd0);

    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      cycle();
    end
    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter: ALUCW, 3, ALU control width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 opcode_d  input  6  opcode of InstrD.
REQ-005 funct_d  input  6  funct field of InstrD.
REQ-006 rs_d, rt_d  input  5 each  source register fields of InstrD.
REQ-007 rt_e  input  5  rt field held in the execute pipeline register.
REQ-008 zero_m  input  1  registered ALU zero flag (memory stage).
REQ-009 reg_dst_e, alu_src_e  output  1 each  execute-stage mux selects.
REQ-010 alu_control_e  output  ALUCW  execute-stage ALU operation.
REQ-011 mem_write_m  output  1  data-memory write enable.
REQ-012 reg_write_w, mem_to_reg_w  output  1 each  writeback controls.
REQ-013 pc_src  output  1  branch-taken select for the PC mux.
REQ-014 jump_d  output  1  decode-stage jump indication.
REQ-015 stall_f, stall_d  output  1 each  hold PC / decode register.
REQ-016 flush_d, flush_e  output  1 each  clear decode / execute pipeline registers.

Function
REQ-017 Decode SHALL be combinational on opcode_d/funct_d: R-type 000000 -> reg_write, reg_dst; lw 100011 -> reg_write, alu_src, mem_to_reg; sw 101011 -> alu_src, mem_write; beq 000100 -> branch; addi 001000 -> reg_write, alu_src; j 000010 -> jump_d only.
REQ-018 ALU control SHALL be 010 for lw/sw/addi, 110 for beq; for R-type funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct -> 010 with reg_write cleared.
REQ-019 Any unlisted opcode SHALL decode to all-zero controls (bubble).
REQ-020 Decoded controls SHALL pass through D->E, E->M, M->W registers; only fields still needed advance (E: all; M: reg_write, mem_to_reg, mem_write, branch; W: reg_write, mem_to_reg).
REQ-021 Latency: an instruction's alu_control_e appears 1 cycle after decode, mem_write_m 2 cycles, reg_write_w 3 cycles.
REQ-022 pc_src SHALL equal branch_m AND zero_m, combinational.
REQ-023 Load-use: when mem_to_reg_e=1, rt_e!=0 and (rt_e==rs_d or rt_e==rt_d), stall_f=stall_d=flush_e=1 for exactly that cycle; E controls load zero.
REQ-024 Branch taken (pc_src=1): flush_d=flush_e=1 and M-stage control register loads zero on the next edge.
REQ-025 Simultaneous pc_src and load-use: pc_src wins; stall_f=stall_d=0, flushes asserted.
REQ-026 Stalls SHALL never exceed one consecutive cycle per load-use pair.

Reset
REQ-027 While reset=0 all pipeline control registers SHALL clear asynchronously; every output SHALL read 0 (pc_src, stalls, flushes included).
REQ-028 Reset mid-operation SHALL discard all in-flight controls; first decoded instruction after release reaches W 3 cycles later.

Configuration
REQ-029 Macro PIPE_CTRL_HAZARD_EN: defined -> REQ-023..REQ-026 active; undefined -> stall_f, stall_d, flush_d, flush_e tied 0, M-stage flush suppressed, rs_d/rt_d/rt_e unused.

Verification
REQ-030 Reset held low 3 cycles with opcode_d=100011 -> all outputs 0; release -> alu_src_e=1, alu_control_e=010 next cycle.
REQ-031 add (000000/100000) then sub (100010) back-to-back -> alu_control_e 010 then 110 on consecutive cycles; reg_write_w=1 both, 3 cycles after each decode.
REQ-032 lw rt=5 in E, decode rs_d=5 -> stall_f=stall_d=flush_e=1 one cycle; repeat with rt_e=0 -> no stall.
REQ-033 beq with zero_m=1 in M -> pc_src=1, flush_d=flush_e=1, mem_write_m=0 next cycle despite sw previously in E.
REQ-034 beq taken coincident with load-use match -> stall_f=0, flush_e=1.
REQ-035 With PIPE_CTRL_HAZARD_EN undefined, REQ-032 stimulus -> stall_f=stall_d=flush_e=0.
